cve2_register_file_dual_wr: RTL and testbench

CVE2_REGISTER_FILE_DUAL_WR -- requirements
Module: cve2_register_file_dual_wr

---
 rtl/cve2_register_file_dual_wr.sv | 100 ++++++++++
 tb/tb_cve2_register_file_dual_wr.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_register_file_dual_wr.sv
// Flop-based register file with two combinational read ports and two write
// ports. Same-address dual writes resolve to port A and are flagged/counted.
// In RV32E mode address bit 4 is ignored for indexing and raises a sticky error.
module cve2_register_file_dual_wr #(
    parameter bit                   RV32E       = 1'b0,
    parameter int unsigned          DataWidth   = 32,
    parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [4:0]           raddr_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    input  logic [4:0]           raddr_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic [4:0]           waddr_a_i,
    input  logic [DataWidth-1:0] wdata_a_i,
    input  logic                 we_a_i,
    input  logic [4:0]           waddr_b_i,
    input  logic [DataWidth-1:0] wdata_b_i,
    input  logic                 we_b_i,
    output logic                 wr_conflict_o,
    output logic [7:0]           wr_conflict_cnt_o,
    output logic                 err_addr_o
);

    localparam int unsigned NumRegs = RV32E ? 16 : 32;

    // x0 has no storage; index 0 is never allocated.
    logic [DataWidth-1:0] rf_q [NumRegs-1:1];

    logic [4:0]         ra_a, ra_b, wa_a, wa_b;
    logic               wr_a, wr_b, conflict, err_set;
    logic [NumRegs-1:1] we_a_dec, we_b_dec;
    logic               conflict_q;
    logic [7:0]         cnt_q;
    logic               err_q;

    // Effective addresses, write qualification, conflict and error detection.
    always_comb begin
        ra_a = RV32E ? {1'b0, raddr_a_i[3:0]} : raddr_a_i;
        ra_b = RV32E ? {1'b0, raddr_b_i[3:0]} : raddr_b_i;
        wa_a = RV32E ? {1'b0, waddr_a_i[3:0]} : waddr_a_i;
        wa_b = RV32E ? {1'b0, waddr_b_i[3:0]} : waddr_b_i;
        // Writes that land on x0 are dropped and cannot conflict.
        wr_a     = we_a_i && (wa_a != 5'd0);
        wr_b     = we_b_i && (wa_b != 5'd0);
        conflict = wr_a && wr_b && (wa_a == wa_b);
        err_set  = RV32E && ((we_a_i && waddr_a_i[4]) || (we_b_i && waddr_b_i[4]) ||
                             raddr_a_i[4] || raddr_b_i[4]);
        we_a_dec = '0;
        we_b_dec = '0;
        for (int i = 1; i < NumRegs; i++) begin
            we_a_dec[i] = wr_a && (wa_a == 5'(i));
            we_b_dec[i] = wr_b && (wa_b == 5'(i));
        end
    end

    // Combinational read mux; no bypass of in-flight write data.
    always_comb begin
        rdata_a_o = WordZeroVal;
        rdata_b_o = WordZeroVal;
        for (int i = 1; i < NumRegs; i++) begin
            if (ra_a == 5'(i)) rdata_a_o = rf_q[i];
            if (ra_b == 5'(i)) rdata_b_o = rf_q[i];
        end
    end

    // Register storage; port A has priority on a shared address.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < NumRegs; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 1; i < NumRegs; i++) begin
                if (we_a_dec[i]) begin
                    rf_q[i] <= wdata_a_i;
                end else if (we_b_dec[i]) begin
                    rf_q[i] <= wdata_b_i;
                end
            end
        end
    end

    // Conflict pulse, saturating conflict counter and sticky address error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= 1'b0;
            cnt_q      <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            conflict_q <= conflict;
            if (conflict && (cnt_q != 8'hFF)) cnt_q <= cnt_q + 8'd1;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign wr_conflict_o     = conflict_q;
    assign wr_conflict_cnt_o = cnt_q;
    assign err_addr_o        = err_q;

endmodule

// File: tb/tb_cve2_register_file_dual_wr.sv
// Self-checking bench: one RV32I instance and one RV32E instance share stimulus.
// Expected read values are queued when writes are driven and compared later.
module tb_cve2_register_file_dual_wr;

    logic        clk;
    logic        rst_n;
    logic [4:0]  raddr_a, raddr_b, waddr_a, waddr_b;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b;
    logic [31:0] rdata_a, rdata_b, rdata_a_e, rdata_b_e;
    logic        conflict, conflict_e, err, err_e;
    logic [7:0]  cnt, cnt_e;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb[$];
    logic [31:0] model [32];
    logic [7:0]  exp_cnt;

    cve2_register_file_dual_wr #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_a_i(raddr_a), .rdata_a_o(rdata_a), .raddr_b_i(raddr_b), .rdata_b_o(rdata_b),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .wr_conflict_o(conflict), .wr_conflict_cnt_o(cnt), .err_addr_o(err)
    );

    cve2_register_file_dual_wr #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(32'h0)) dut_e (
        .clk_i(clk), .rst_ni(rst_n),
        .raddr_a_i(raddr_a), .rdata_a_o(rdata_a_e), .raddr_b_i(raddr_b), .rdata_b_o(rdata_b_e),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .wr_conflict_o(conflict_e), .wr_conflict_cnt_o(cnt_e), .err_addr_o(err_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string name, input logic [4:0] addr, input logic [31:0] exp);
        sb_item_t it;
        it.name = name;
        it.addr = addr;
        it.exp  = exp;
        sb.push_back(it);
    endtask

    task automatic idle_inputs();
        we_a = 1'b0;
        we_b = 1'b0;
        waddr_a = 5'd0;
        waddr_b = 5'd0;
        wdata_a = '0;
        wdata_b = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            #1;
            checks++;
            if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
                fails++;
                $display("FAIL reset_read addr=%0d got a=%h b=%h want 0", i, rdata_a, rdata_b);
            end
        end
        checks++;
        if (conflict !== 1'b0 || cnt !== 8'd0 || err !== 1'b0 || err_e !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags got conflict=%b cnt=%0d err=%b err_e=%b want 0",
                     conflict, cnt, err, err_e);
        end
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_cnt = 8'd0;
    endtask

    task automatic test_reset_mid_write();
        sb_item_t e;
        @(negedge clk);
        rst_n = 1'b0;
        we_a = 1'b1;
        waddr_a = 5'd4;
        wdata_a = 32'hCAFE0004;
        raddr_a = 5'd4;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rdata_a !== 32'h0) begin
            fails++;
            $display("FAIL reset_wins got %h want 0", rdata_a);
        end
        // Release with the write still pending: first high edge must take it.
        rst_n = 1'b1;
        model[4] = 32'hCAFE0004;
        push("first_write_after_reset", 5'd4, 32'hCAFE0004);
        @(negedge clk);
        idle_inputs();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr_a = e.addr;
            raddr_b = e.addr;
            #1;
            checks++;
            if (rdata_a !== e.exp || rdata_b !== e.exp) begin
                fails++;
                $display("FAIL %s x%0d got a=%h b=%h want %h", e.name, e.addr, rdata_a, rdata_b,
                         e.exp);
            end
        end
    endtask

    task automatic test_write_read();
        sb_item_t e;
        @(negedge clk);
        we_a = 1'b1;
        waddr_a = 5'd5;
        wdata_a = 32'hDEADBEEF;
        raddr_a = 5'd5;
        #1;
        checks++;
        if (rdata_a !== model[5]) begin
            fails++;
            $display("FAIL no_bypass got %h want %h", rdata_a, model[5]);
        end
        model[5] = 32'hDEADBEEF;
        push("port_a_write", 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        // Port B alone.
        we_a = 1'b0;
        we_b = 1'b1;
        waddr_b = 5'd6;
        wdata_b = 32'h12345678;
        model[6] = 32'h12345678;
        push("port_b_write", 5'd6, 32'h12345678);
        @(negedge clk);
        idle_inputs();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr_a = e.addr;
            raddr_b = e.addr;
            #1;
            checks++;
            if (rdata_a !== e.exp || rdata_b !== e.exp) begin
                fails++;
                $display("FAIL %s x%0d got a=%h b=%h want %h", e.name, e.addr, rdata_a, rdata_b,
                         e.exp);
            end
        end
    endtask

    task automatic test_dual_write();
        sb_item_t e;
        @(negedge clk);
        we_a = 1'b1;
        we_b = 1'b1;
        waddr_a = 5'd7;
        wdata_a = 32'h11111111;
        waddr_b = 5'd9;
        wdata_b = 32'h22222222;
        model[7] = 32'h11111111;
        model[9] = 32'h22222222;
        push("dual_a", 5'd7, 32'h11111111);
        push("dual_b", 5'd9, 32'h22222222);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (conflict !== 1'b0 || cnt !== exp_cnt) begin
            fails++;
            $display("FAIL dual_no_conflict got conflict=%b cnt=%0d want 0/%0d", conflict, cnt,
                     exp_cnt);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr_a = e.addr;
            raddr_b = e.addr;
            #1;
            checks++;
            if (rdata_a !== e.exp || rdata_b !== e.exp) begin
                fails++;
                $display("FAIL %s x%0d got a=%h b=%h want %h", e.name, e.addr, rdata_a, rdata_b,
                         e.exp);
            end
        end
    endtask

    task automatic test_conflict();
        sb_item_t e;
        @(negedge clk);
        we_a = 1'b1;
        we_b = 1'b1;
        waddr_a = 5'd3;
        waddr_b = 5'd3;
        wdata_a = 32'hAAAA0000;
        wdata_b = 32'h0000BBBB;
        model[3] = 32'hAAAA0000;
        exp_cnt = 8'd1;
        push("conflict_a_wins", 5'd3, 32'hAAAA0000);
        @(negedge clk);
        idle_inputs();
        checks++;
        if (conflict !== 1'b1 || cnt !== exp_cnt) begin
            fails++;
            $display("FAIL conflict_pulse got conflict=%b cnt=%0d want 1/%0d", conflict, cnt,
                     exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (conflict !== 1'b0) begin
            fails++;
            $display("FAIL conflict_one_cycle got %b want 0", conflict);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr_a = e.addr;
            raddr_b = e.addr;
            #1;
            checks++;
            if (rdata_a !== e.exp || rdata_b !== e.exp) begin
                fails++;
                $display("FAIL %s x%0d got a=%h b=%h want %h", e.name, e.addr, rdata_a, rdata_b,
                         e.exp);
            end
        end
        // Hold a conflicting write for 300 edges; counter must stop at 255.
        @(negedge clk);
        we_a = 1'b1;
        we_b = 1'b1;
        waddr_a = 5'd3;
        waddr_b = 5'd3;
        wdata_a = 32'hAAAA0000;
        wdata_b = 32'h0000BBBB;
        repeat (300) @(negedge clk);
        exp_cnt = 8'd255;
        checks++;
        if (cnt !== exp_cnt || conflict !== 1'b1) begin
            fails++;
            $display("FAIL conflict_saturate got cnt=%0d conflict=%b want 255/1", cnt, conflict);
        end
        @(negedge clk);
        idle_inputs();
        checks++;
        if (cnt !== exp_cnt) begin
            fails++;
            $display("FAIL conflict_no_wrap got %0d want 255", cnt);
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        we_a = 1'b1;
        we_b = 1'b1;
        waddr_a = 5'd0;
        waddr_b = 5'd0;
        wdata_a = 32'hFFFFFFFF;
        wdata_b = 32'hFFFFFFFF;
        @(negedge clk);
        idle_inputs();
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        #1;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            fails++;
            $display("FAIL x0_read got a=%h b=%h want 0", rdata_a, rdata_b);
        end
        checks++;
        if (conflict !== 1'b0 || cnt !== exp_cnt) begin
            fails++;
            $display("FAIL x0_no_conflict got conflict=%b cnt=%0d want 0/%0d", conflict, cnt,
                     exp_cnt);
        end
    endtask

    task automatic test_no_we();
        sb_item_t e;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            we_a = 1'b0;
            we_b = 1'b0;
            waddr_a = 5'($urandom_range(0, 31));
            waddr_b = 5'($urandom_range(0, 31));
            wdata_a = $urandom;
            wdata_b = $urandom;
        end
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 32; i++) push("no_we_hold", 5'(i), model[i]);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            raddr_a = e.addr;
            raddr_b = e.addr;
            #1;
            checks++;
            if (rdata_a !== e.exp || rdata_b !== e.exp) begin
                fails++;
                $display("FAIL %s x%0d got a=%h b=%h want %h", e.name, e.addr, rdata_a, rdata_b,
                         e.exp);
            end
        end
    endtask

    task automatic test_rv32e();
        @(negedge clk);
        idle_inputs();
        raddr_a = 5'd1;
        raddr_b = 5'd17;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = '0;
        @(negedge clk);
        raddr_b = 5'd1;
        we_a = 1'b1;
        waddr_a = 5'd17;
        wdata_a = 32'h0000005A;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rdata_a_e !== 32'h5A || rdata_b_e !== 32'h5A || err_e !== 1'b1) begin
            fails++;
            $display("FAIL rv32e_alias got x1=%h/%h err=%b want 5a/1", rdata_a_e, rdata_b_e,
                     err_e);
        end
        // Full-size instance keeps x17 distinct and never flags an error.
        raddr_a = 5'd17;
        #1;
        checks++;
        if (rdata_a !== 32'h5A || rdata_b !== 32'h0 || err !== 1'b0) begin
            fails++;
            $display("FAIL rv32i_x17 got x17=%h x1=%h err=%b want 5a/0/0", rdata_a, rdata_b, err);
        end
        raddr_a = 5'd1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err_e !== 1'b1) begin
            fails++;
            $display("FAIL rv32e_err_sticky got %b want 1", err_e);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdata_a_e !== 32'h0 || err_e !== 1'b0) begin
            fails++;
            $display("FAIL rv32e_reset got x1=%h err=%b want 0/0", rdata_a_e, err_e);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        raddr_a = 5'd0;
        raddr_b = 5'd0;
        idle_inputs();
        test_reset();
        test_reset_mid_write();
        test_write_read();
        test_dual_write();
        test_conflict();
        test_x0_write();
        test_no_we();
        test_rv32e();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
